// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the fetch PC, issues 1-cycle-latency instruction memory
// reads and buffers PC-tagged instructions in a DEPTH-entry queue toward decode.
module fetch_queue_unit #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_o,
  output logic [AW-1:0]              imem_addr_o,
  input  logic [DW-1:0]              imem_rdata_i,
  input  logic                       redirect_i,
  input  logic [AW-1:0]              redirect_pc_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [DW-1:0]              instr_o,
  output logic [AW-1:0]              instr_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] ipc_q, ipc_d;

  logic [DW-1:0] data_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q [DEPTH];

  logic          pop;
  logic          push;
  logic          req;
  logic [CW:0]   occ;
  logic [CW-1:0] remain;

  // Occupancy counts the in-flight slot so the queue can never overflow.
  assign pop    = (count_q != '0) & instr_ready_i;
  assign occ    = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign req    = ~rst & ~redirect_i & (occ < (CW+1)'(DEPTH));
  assign push   = inflight_q & ~drop_q & ~redirect_i;
  assign remain = count_q - CW'(pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = fetch_pc_q;
    inflight_d = req;
    drop_d     = redirect_i & inflight_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    instr_d    = instr_q;
    ipc_d      = ipc_q;

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[AW-1:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req) begin
        fetch_pc_d = fetch_pc_q + AW'(4);
      end
      // Head register tracks the next head; it holds its value when the queue drains.
      if (remain == '0) begin
        if (push) begin
          instr_d = imem_rdata_i;
          ipc_d   = req_pc_q;
        end
      end else begin
        instr_d = data_mem_q[rd_ptr_d];
        ipc_d   = pc_mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      instr_q    <= '0;
      ipc_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: three instances (DEPTH 4, 2, 8) against a ROM model,
// with a PC/instruction scoreboard checked on every pop.
module tb_fetch_queue_unit;

  logic        clk;
  logic        rst_a   [3];
  logic        rdy_a   [3];
  logic        redir_a [3];
  logic [31:0] tgt_a   [3];
  logic        req_a   [3];
  logic [31:0] addr_a  [3];
  logic        vld_a   [3];
  logic [31:0] instr_a [3];
  logic [31:0] ipc_a   [3];
  logic [3:0]  cnt_a   [3];

  logic [31:0] exp_q [$];
  int n_chk;
  int n_fail;
  int npop;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 1) ? 2 : ((g == 2) ? 8 : 4);
    localparam logic [31:0] RPC = (g == 2) ? 32'hFFFF_FFF8 : 32'h0;
    localparam int CW = $clog2(D) + 1;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata;

    fetch_queue_unit #(.DW(32), .AW(32), .DEPTH(D), .RESET_PC(RPC)) u_dut (
      .clk          (clk),
      .rst          (rst_a[g]),
      .imem_req_o   (req_a[g]),
      .imem_addr_o  (addr_a[g]),
      .imem_rdata_i (rdata),
      .redirect_i   (redir_a[g]),
      .redirect_pc_i(tgt_a[g]),
      .instr_valid_o(vld_a[g]),
      .instr_ready_i(rdy_a[g]),
      .instr_o      (instr_a[g]),
      .instr_pc_o   (ipc_a[g]),
      .count_o      (cnt)
    );

    assign cnt_a[g] = 4'(cnt);

    always @(posedge clk) rdata <= rom(addr_a[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 80; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1 time unit later.
  task automatic tick(input int g, input logic r, input logic rd, input logic rdir,
                      input logic [31:0] tgt);
    logic [31:0] e;
    @(negedge clk);
    rst_a[g]   = r;
    rdy_a[g]   = rd;
    redir_a[g] = rdir;
    tgt_a[g]   = tgt;
    #1;
    if (!r && rd && vld_a[g]) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ~ipc_a[g];
      check("pop_pc", 64'(ipc_a[g]), 64'(e));
      check("pop_instr", 64'(instr_a[g]), 64'(rom(e)));
      npop++;
    end
    if (!r && rdir) expect_stream({tgt[31:2], 2'b00});
  endtask

  task automatic do_reset(input int g, input logic [31:0] start);
    tick(g, 1'b1, 1'b0, 1'b0, 32'h0);
    tick(g, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_stream(start);
  endtask

  task automatic run_random(input int g, input int depth, input int n);
    int target;
    int budget;
    target = npop + n;
    budget = 0;
    while (npop < target && budget < 2000) begin
      tick(g, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      check("cnt_bound", 64'(cnt_a[g] <= 4'(depth)), 64'(1));
      budget++;
    end
    check("rand_progress", 64'(npop >= target), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    npop = 0;
    for (int g = 0; g < 3; g++) begin
      rst_a[g] = 1'b1;
      rdy_a[g] = 1'b0;
      redir_a[g] = 1'b0;
      tgt_a[g] = 32'h0;
    end

    // Reset values
    do_reset(0, 32'h0);
    check("rst_req", 64'(req_a[0]), 64'(0));
    check("rst_valid", 64'(vld_a[0]), 64'(0));
    check("rst_count", 64'(cnt_a[0]), 64'(0));
    check("rst_instr", 64'(instr_a[0]), 64'(0));
    check("rst_pc", 64'(ipc_a[0]), 64'(0));

    // Streaming with ready high
    for (int c = 0; c < 8; c++) begin
      tick(0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("seq_req", 64'(req_a[0]), 64'(1));
      check("seq_addr", 64'(addr_a[0]), 64'(4 * c));
      check("seq_valid", 64'(vld_a[0]), 64'(c >= 2));
      if (c == 2) check("first_instr", 64'(instr_a[0]), 64'(32'h1000));
    end

    // Build two queued entries with a request to 0x20 outstanding, then redirect
    tick(0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("pre_redir_addr", 64'(addr_a[0]), 64'(32'h20));
    tick(0, 1'b0, 1'b0, 1'b1, 32'h103);
    check("pre_redir_cnt", 64'(cnt_a[0]), 64'(2));
    check("redir_no_req", 64'(req_a[0]), 64'(0));
    tick(0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("post_redir_cnt", 64'(cnt_a[0]), 64'(0));
    check("post_redir_valid", 64'(vld_a[0]), 64'(0));
    check("post_redir_req", 64'(req_a[0]), 64'(1));
    check("post_redir_addr", 64'(addr_a[0]), 64'(32'h100));
    tick(0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("redir_valid_c1", 64'(vld_a[0]), 64'(0));
    tick(0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("redir_valid_c2", 64'(vld_a[0]), 64'(1));
    check("redir_head_pc", 64'(ipc_a[0]), 64'(32'h100));
    tick(0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick(0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Back-to-back redirects: last one wins
    tick(0, 1'b0, 1'b1, 1'b1, 32'h200);
    tick(0, 1'b0, 1'b1, 1'b1, 32'h300);
    check("b2b_valid", 64'(vld_a[0]), 64'(0));
    check("b2b_no_req", 64'(req_a[0]), 64'(0));
    for (int c = 0; c < 5; c++) begin
      tick(0, 1'b0, 1'b1, 1'b0, 32'h0);
      if (c == 0) check("b2b_addr", 64'(addr_a[0]), 64'(32'h300));
      if (c == 2) check("b2b_head_pc", 64'(ipc_a[0]), 64'(32'h300));
    end

    // Backpressure: fill to DEPTH, then drain without gaps
    do_reset(0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      tick(0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("bp_req", 64'(req_a[0]), 64'(c < 4));
      if (c < 4) check("bp_addr", 64'(addr_a[0]), 64'(4 * c));
    end
    check("bp_full", 64'(cnt_a[0]), 64'(4));
    check("bp_head_stable", 64'(ipc_a[0]), 64'(0));
    for (int c = 0; c < 8; c++) begin
      tick(0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("drain_valid", 64'(vld_a[0]), 64'(1));
      if (c == 0) begin
        check("resume_req", 64'(req_a[0]), 64'(1));
        check("resume_addr", 64'(addr_a[0]), 64'(32'h10));
      end
    end

    // DEPTH=2: full throughput, then random backpressure
    do_reset(1, 32'h0);
    for (int c = 0; c < 12; c++) begin
      tick(1, 1'b0, 1'b1, 1'b0, 32'h0);
      if (c >= 2) check("d2_thru_valid", 64'(vld_a[1]), 64'(1));
    end
    run_random(1, 2, 60);

    // DEPTH=8, RESET_PC near the top: address wrap, then reset mid-stream
    do_reset(2, 32'hFFFF_FFF8);
    for (int c = 0; c < 6; c++) begin
      tick(2, 1'b0, 1'b1, 1'b0, 32'h0);
      if (c == 4) check("wrap_pc", 64'(ipc_a[2]), 64'(0));
    end
    tick(2, 1'b1, 1'b1, 1'b0, 32'h0);
    check("mid_rst_req", 64'(req_a[2]), 64'(0));
    expect_stream(32'hFFFF_FFF8);
    tick(2, 1'b0, 1'b1, 1'b0, 32'h0);
    check("mid_rst_cnt", 64'(cnt_a[2]), 64'(0));
    check("mid_rst_valid", 64'(vld_a[2]), 64'(0));
    check("mid_rst_req2", 64'(req_a[2]), 64'(1));
    check("mid_rst_addr", 64'(addr_a[2]), 64'(32'hFFFF_FFF8));
    for (int c = 0; c < 3; c++) tick(2, 1'b0, 1'b1, 1'b0, 32'h0);
    run_random(2, 8, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-cycle PC/instruction-ROM fetch path.
- Owns the fetch PC and issues requests to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue with a valid/ready handshake to decode.
- Supports branch/jump redirect with flush and discard of in-flight responses; this is the front end for the pipelined core.

Parameters:
- DW, 32, instruction width.
- AW, 32, PC/address width.
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req_o  output  1  fetch request this cycle.
- imem_addr_o  output  AW  fetch address; valid when imem_req_o=1.
- imem_rdata_i  input  DW  instruction data, valid the cycle after the request.
- redirect_i  input  1  redirect fetch stream (taken branch or jump).
- redirect_pc_i  input  AW  redirect target; bits [1:0] ignored and forced to 0.
- instr_valid_o  output  1  queue head valid.
- instr_ready_i  input  1  decode accepts the head.
- instr_o  output  DW  head instruction.
- instr_pc_o  output  AW  PC of the head instruction.
- count_o  output  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Single clock domain. Synchronous active-high reset. All state is registered.
- Reset values:
  - fetch_pc=RESET_PC; queue empty with read/write pointers 0; inflight=0; drop flag=0.
  - imem_req_o=0, instr_valid_o=0, count_o=0, instr_o=0, instr_pc_o=0.
- pop = instr_valid_o & instr_ready_i.
- Request rule:
  - imem_req_o = !rst & !redirect_i & ((count + inflight - pop) < DEPTH).
  - imem_addr_o = fetch_pc.
  - On request, fetch_pc <= fetch_pc + 4, wrapping modulo 2^AW.
  - inflight <= imem_req_o; at most one request is outstanding.
- Response: in the cycle after a request, imem_rdata_i is written to the queue tail together with its request PC, unless the drop flag is set.
  - Entry becomes visible on instr_valid_o the following cycle; there is no bypass.
  - Latency from request to instr_valid_o is 2 cycles.
- Throughput: with instr_ready_i held high, one instruction per cycle sustained for any DEPTH>=2.
- Queue:
  - Circular buffer; pointers wrap at DEPTH.
  - Simultaneous push and pop is legal at any occupancy, including full, and leaves count unchanged.
  - The request rule guarantees no overflow; pop when empty is ignored.
- Outputs: instr_o, instr_pc_o and count_o come directly from registered state. instr_o/instr_pc_o hold their last value when empty.
- Redirect (priority over all except rst):
  - In the redirect cycle: queue flushed (count<=0, pointers reset); fetch_pc <= {redirect_pc_i[AW-1:2],2'b00}; no request issued.
  - If a request was issued in the redirect cycle's predecessor (inflight=1), the drop flag is set and that response is discarded next cycle.
  - A head popped in the redirect cycle counts as consumed.
  - instr_valid_o=0 in the following cycle.
  - The first request to the target is issued the cycle after redirect, and its instruction is valid 2 cycles later.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: all state returns to reset values in the same edge. An in-flight response arriving after reset is ignored (inflight=0).
- Backpressure: with instr_ready_i=0, requests continue until count+inflight=DEPTH, then stop. Entries remain stable.

Test Plan:
- Release rst, ready=1, ROM[i]=0x1000+i → imem_addr 0,4,8… from the first post-reset cycle; first instr_valid_o 2 cycles later with instr=0x1000, pc=0; then one instruction per cycle in order.
- DEPTH=4, ready=0 after reset → exactly 4 requests (addr 0..0xC); count_o=4; imem_req_o=0 thereafter. Raise ready → pcs 0,4,8,C popped on consecutive cycles, fetching resumes at 0x10 without gaps.
- Redirect to 0x103 with one request outstanding to 0x20 and 2 queued entries → next cycle count_o=0, valid=0, 0x20 data dropped; imem_addr=0x100 one cycle after redirect; instr_pc_o=0x100 valid 2 cycles later.
- Redirect on two consecutive cycles to 0x200 then 0x300 → only 0x300 is fetched; no 0x200-stream entry ever appears.
- Random ready toggling over 50+ instructions with DEPTH=2 and DEPTH=8 → in-order PCs, no loss or duplication, count_o never >DEPTH; pointer wrap exercised.
- RESET_PC=0xFFFFFFF8, ready=1 → pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Assert rst mid-stream → next cycle count_o=0, valid=0, and the first request is to RESET_PC again.
